// File: rtl/dataflow_proc_sequencer.sv
// dataflow_proc_sequencer
// Handshake sequencer for a two-process dataflow region (block process and
// zero-padding process). It fans the region start out to each process,
// latches the per-process ready/done pulses until every process has reported,
// and then releases the region-level ap_ready / ap_done. Iteration counters,
// a progress watchdog and a sticky done-overflow flag are kept for debug and
// for the simulation deadlock detector.
module dataflow_proc_sequencer #(
   parameter int NUM_PROC   = 2,
   parameter int ITER_W     = 16,
   parameter int WDOG_W     = 16,
   parameter int WDOG_LIMIT = 1000
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                i_ap_start,
   input  logic                i_ap_continue,
   output logic                o_ap_ready,
   output logic                o_ap_done,
   output logic                o_ap_idle,
   output logic [NUM_PROC-1:0] o_proc_start,
   input  logic [NUM_PROC-1:0] i_proc_ready,
   input  logic [NUM_PROC-1:0] i_proc_done,
   input  logic [NUM_PROC-1:0] i_proc_idle,
   output logic [NUM_PROC-1:0] o_ready_count,
   output logic [ITER_W-1:0]   o_iter_started,
   output logic [ITER_W-1:0]   o_iter_finished,
   output logic [ITER_W-1:0]   o_inflight,
   output logic                o_stall,
   output logic                o_done_ovf
);

   localparam logic [WDOG_W-1:0] LP_WDOG_LIMIT = WDOG_W'(WDOG_LIMIT);
   localparam logic [WDOG_W-1:0] LP_WDOG_ONE   = WDOG_W'(1);
   localparam logic [ITER_W-1:0] LP_ITER_ONE   = ITER_W'(1);

   logic [NUM_PROC-1:0] r_ready_count;
   logic [NUM_PROC-1:0] r_done_count;
   logic [ITER_W-1:0]   r_iter_started;
   logic [ITER_W-1:0]   r_iter_finished;
   logic [WDOG_W-1:0]   r_wdog;
   logic                r_done_ovf;

   logic                w_all_ready;
   logic                w_all_done;
   logic                w_done_sync;
   logic                w_progress;
   logic                w_active;

   // Region handshakes are combinational so a process reporting in the same
   // cycle as the last outstanding one syncs with zero latency.
   assign w_all_ready     = &(r_ready_count | i_proc_ready);
   assign o_ap_ready      = i_ap_start & w_all_ready;
   assign o_proc_start    = {NUM_PROC{i_ap_start}} & ~r_ready_count;

   assign w_all_done      = &(r_done_count | i_proc_done);
   assign o_ap_done       = w_all_done;
   assign w_done_sync     = w_all_done & i_ap_continue;

   assign o_ap_idle       = &i_proc_idle;
   assign o_ready_count   = r_ready_count;
   assign o_iter_started  = r_iter_started;
   assign o_iter_finished = r_iter_finished;
   assign o_inflight      = r_iter_started - r_iter_finished;
   assign o_done_ovf      = r_done_ovf;

   // Watchdog only runs while the region has work pending (start requested
   // or iterations still in flight); any handshake counts as progress.
   assign w_progress      = (|i_proc_ready) | (|i_proc_done) | o_ap_ready;
   assign w_active        = i_ap_start | (o_inflight != '0);
   assign o_stall         = (r_wdog == LP_WDOG_LIMIT);

   // Latch per-process ready flags until the region accepts the input.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_ready_count <= '0;
      end else if (o_ap_ready) begin
         r_ready_count <= '0;
      end else begin
         r_ready_count <= r_ready_count | ({NUM_PROC{i_ap_start}} & i_proc_ready);
      end
   end

   // Latch per-process done flags; once all are set ap_done holds until
   // ap_continue. A done pulse on an already-latched slot is a lost event.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_done_count <= '0;
         r_done_ovf   <= 1'b0;
      end else begin
         if (w_done_sync) begin
            r_done_count <= '0;
         end else begin
            r_done_count <= r_done_count | i_proc_done;
            if (|(i_proc_done & r_done_count)) begin
               r_done_ovf <= 1'b1;
            end
         end
      end
   end

   // Iteration counters wrap naturally; inflight is their modular difference.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_iter_started  <= '0;
         r_iter_finished <= '0;
      end else begin
         if (o_ap_ready) begin
            r_iter_started <= r_iter_started + LP_ITER_ONE;
         end
         if (w_done_sync) begin
            r_iter_finished <= r_iter_finished + LP_ITER_ONE;
         end
      end
   end

   // Idle-progress watchdog, saturating at the limit.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wdog <= '0;
      end else if (w_progress || !w_active) begin
         r_wdog <= '0;
      end else if (r_wdog != LP_WDOG_LIMIT) begin
         r_wdog <= r_wdog + LP_WDOG_ONE;
      end
   end

endmodule

// File: tb/tb_dataflow_proc_sequencer.sv
// Self-checking bench for dataflow_proc_sequencer: directed handshake
// scenarios followed by randomized traffic, compared each cycle against a
// behavioural model of the region's ready/done bookkeeping.
module tb_dataflow_proc_sequencer;

   localparam int NP = 2;
   localparam int IW = 4;
   localparam int WW = 8;
   localparam int WL = 8;
   localparam int IMOD = 1 << IW;

   logic          clock;
   logic          reset;
   logic          i_ap_start;
   logic          i_ap_continue;
   logic          o_ap_ready;
   logic          o_ap_done;
   logic          o_ap_idle;
   logic [NP-1:0] o_proc_start;
   logic [NP-1:0] i_proc_ready;
   logic [NP-1:0] i_proc_done;
   logic [NP-1:0] i_proc_idle;
   logic [NP-1:0] o_ready_count;
   logic [IW-1:0] o_iter_started;
   logic [IW-1:0] o_iter_finished;
   logic [IW-1:0] o_inflight;
   logic          o_stall;
   logic          o_done_ovf;

   dataflow_proc_sequencer #(
      .NUM_PROC   (NP),
      .ITER_W     (IW),
      .WDOG_W     (WW),
      .WDOG_LIMIT (WL)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .i_ap_start      (i_ap_start),
      .i_ap_continue   (i_ap_continue),
      .o_ap_ready      (o_ap_ready),
      .o_ap_done       (o_ap_done),
      .o_ap_idle       (o_ap_idle),
      .o_proc_start    (o_proc_start),
      .i_proc_ready    (i_proc_ready),
      .i_proc_done     (i_proc_done),
      .i_proc_idle     (i_proc_idle),
      .o_ready_count   (o_ready_count),
      .o_iter_started  (o_iter_started),
      .o_iter_finished (o_iter_finished),
      .o_inflight      (o_inflight),
      .o_stall         (o_stall),
      .o_done_ovf      (o_done_ovf)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: which processes have reported, plus plain integer counts.
   bit m_rdy  [NP];
   bit m_done [NP];
   bit m_ovf;
   int m_started;
   int m_finished;
   int m_idle_cycles;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NP; i++) begin
         m_rdy[i]  = 1'b0;
         m_done[i] = 1'b0;
      end
      m_ovf         = 1'b0;
      m_started     = 0;
      m_finished    = 0;
      m_idle_cycles = 0;
   endtask

   function automatic logic [NP-1:0] rbits(input int pct);
      logic [NP-1:0] v;
      for (int i = 0; i < NP; i++) v[i] = ($urandom_range(0, 99) < pct);
      return v;
   endfunction

   // Apply one cycle of inputs (called at a falling edge), check every output
   // against the model, advance the model by the rising edge, and return at
   // the next falling edge.
   task automatic cyc(input logic st, input logic ct, input logic [NP-1:0] rd,
                      input logic [NP-1:0] dn, input logic [NP-1:0] id);
      bit            every_ready, every_done, exp_ready, finish, progress;
      bit            exp_idle;
      logic [NP-1:0] exp_pstart, exp_rc;
      int            infl;
      i_ap_start    = st;
      i_ap_continue = ct;
      i_proc_ready  = rd;
      i_proc_done   = dn;
      i_proc_idle   = id;
      #1;
      every_ready = 1'b1;
      every_done  = 1'b1;
      exp_idle    = 1'b1;
      for (int i = 0; i < NP; i++) begin
         if (!(m_rdy[i] || rd[i])) every_ready = 1'b0;
         if (!(m_done[i] || dn[i])) every_done = 1'b0;
         if (!id[i]) exp_idle = 1'b0;
         exp_pstart[i] = st && !m_rdy[i];
         exp_rc[i]     = m_rdy[i];
      end
      exp_ready = st && every_ready;
      finish    = every_done && ct;
      infl      = (m_started - m_finished + IMOD) % IMOD;

      chk("ap_ready",      32'(o_ap_ready),      32'(exp_ready));
      chk("ap_done",       32'(o_ap_done),       32'(every_done));
      chk("ap_idle",       32'(o_ap_idle),       32'(exp_idle));
      chk("proc_start",    32'(o_proc_start),    32'(exp_pstart));
      chk("ready_count",   32'(o_ready_count),   32'(exp_rc));
      chk("iter_started",  32'(o_iter_started),  32'(m_started));
      chk("iter_finished", 32'(o_iter_finished), 32'(m_finished));
      chk("inflight",      32'(o_inflight),      32'(infl));
      chk("stall",         32'(o_stall),         32'(m_idle_cycles == WL));
      chk("done_ovf",      32'(o_done_ovf),      32'(m_ovf));

      progress = exp_ready || (rd != '0) || (dn != '0);
      for (int i = 0; i < NP; i++) begin
         if (exp_ready) m_rdy[i] = 1'b0;
         else if (st && rd[i]) m_rdy[i] = 1'b1;
         if (finish) m_done[i] = 1'b0;
         else begin
            if (dn[i] && m_done[i]) m_ovf = 1'b1;
            if (dn[i]) m_done[i] = 1'b1;
         end
      end
      if (exp_ready) m_started = (m_started + 1) % IMOD;
      if (finish) m_finished = (m_finished + 1) % IMOD;
      if (progress || !(st || infl != 0)) m_idle_cycles = 0;
      else if (m_idle_cycles < WL) m_idle_cycles++;
      @(negedge clock);
   endtask

   initial begin
      reset         = 1'b0;
      i_ap_start    = 1'b0;
      i_ap_continue = 1'b0;
      i_proc_ready  = '0;
      i_proc_done   = '0;
      i_proc_idle   = '0;
      model_reset();
      repeat (2) @(negedge clock);

      // Reset state, inputs all low.
      chk("rst_ap_ready",    32'(o_ap_ready),     32'd0);
      chk("rst_ap_done",     32'(o_ap_done),      32'd0);
      chk("rst_proc_start",  32'(o_proc_start),   32'd0);
      chk("rst_ready_count", 32'(o_ready_count),  32'd0);
      chk("rst_started",     32'(o_iter_started), 32'd0);
      chk("rst_stall",       32'(o_stall),        32'd0);
      chk("rst_done_ovf",    32'(o_done_ovf),     32'd0);
      reset = 1'b1;

      // Unequal ready: proc 0 at cycle 2, proc 1 at cycle 5.
      cyc(1, 0, 2'b00, 2'b00, 2'b00);
      cyc(1, 0, 2'b00, 2'b00, 2'b00);
      cyc(1, 0, 2'b01, 2'b00, 2'b10);
      cyc(1, 0, 2'b00, 2'b00, 2'b10);
      cyc(1, 0, 2'b00, 2'b00, 2'b10);
      cyc(1, 0, 2'b10, 2'b00, 2'b00);
      cyc(0, 0, 2'b00, 2'b00, 2'b11);
      chk("unequal_started", 32'(o_iter_started), 32'd1);
      chk("unequal_rc",      32'(o_ready_count),  32'd0);

      // Same-cycle ready.
      cyc(1, 0, 2'b11, 2'b00, 2'b00);
      cyc(0, 0, 2'b00, 2'b00, 2'b11);
      chk("same_cycle_started", 32'(o_iter_started), 32'd2);

      // Done backpressure: ap_done holds for four cycles, then continue.
      cyc(0, 0, 2'b00, 2'b11, 2'b00);
      repeat (3) cyc(0, 0, 2'b00, 2'b00, 2'b00);
      chk("bp_ap_done_held", 32'(o_ap_done), 32'd1);
      cyc(0, 1, 2'b00, 2'b00, 2'b00);
      chk("bp_finished", 32'(o_iter_finished), 32'd1);
      chk("bp_ap_done_clr", 32'(o_ap_done), 32'd0);

      // Done overflow: second done[1] pulse while ap_done is held.
      cyc(0, 0, 2'b00, 2'b10, 2'b00);
      cyc(0, 0, 2'b00, 2'b01, 2'b00);
      cyc(0, 0, 2'b00, 2'b10, 2'b00);
      chk("ovf_set", 32'(o_done_ovf), 32'd1);
      cyc(0, 1, 2'b00, 2'b00, 2'b00);
      cyc(0, 0, 2'b00, 2'b00, 2'b00);
      chk("ovf_sticky", 32'(o_done_ovf), 32'd1);

      // Watchdog: start with no progress saturates, a ready pulse clears it.
      repeat (10) cyc(1, 0, 2'b00, 2'b00, 2'b00);
      chk("wdog_stall", 32'(o_stall), 32'd1);
      cyc(1, 0, 2'b01, 2'b00, 2'b00);
      cyc(1, 0, 2'b00, 2'b00, 2'b00);

      // Reset mid-iteration with ready_count=01 and inflight=3.
      cyc(1, 0, 2'b10, 2'b00, 2'b00);
      cyc(1, 0, 2'b11, 2'b00, 2'b00);
      cyc(1, 0, 2'b11, 2'b00, 2'b00);
      cyc(1, 0, 2'b01, 2'b00, 2'b00);
      chk("pre_rst_inflight", 32'(o_inflight),    32'd3);
      chk("pre_rst_rc",       32'(o_ready_count), 32'd1);
      i_proc_ready = '0;
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_rc",       32'(o_ready_count),   32'd0);
      chk("mid_rst_started",  32'(o_iter_started),  32'd0);
      chk("mid_rst_finished", 32'(o_iter_finished), 32'd0);
      chk("mid_rst_inflight", 32'(o_inflight),      32'd0);
      chk("mid_rst_stall",    32'(o_stall),         32'd0);
      chk("mid_rst_ovf",      32'(o_done_ovf),      32'd0);
      model_reset();
      @(negedge clock);
      reset = 1'b1;
      #1;
      chk("post_rst_proc_start", 32'(o_proc_start), 32'd3);
      @(negedge clock);
      model_reset();
      // Clear the one cycle that ran with ap_start=1 and no progress.
      m_idle_cycles = 1;

      // Randomized traffic, busy phase then sparse phase to reach the watchdog.
      for (int n = 0; n < 300; n++)
         cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             rbits(35), rbits(30), rbits(50));
      for (int n = 0; n < 150; n++)
         cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             rbits(4), rbits(4), rbits(50));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
